// File: rtl/memory_block_banked_rl.sv
// memory_block_banked_rl: 1W/1R RAM with byte enables, 1/2-cycle read latency, zero-init sweep and OOB flag.
// Define MEM_BYPASS_EN for write-first forwarding on same-address collisions (default: read-first).
module memory_block_banked_rl #(
  parameter int DATAW        = 128,
  parameter int DEPTH        = 64,
  parameter int ADDRW        = $clog2(DEPTH),
  parameter int READ_LATENCY = 1,
  parameter int ZERO_INIT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wen,
  input  logic [ADDRW-1:0]   waddr,
  input  logic [DATAW-1:0]   wdata,
  input  logic [DATAW/8-1:0] wbe,
  input  logic               ren,
  input  logic [ADDRW-1:0]   raddr,
  output logic               ready,
  output logic               rvalid,
  output logic [DATAW-1:0]   rdata,
  output logic               oob_err
);
  localparam int NB = DATAW / 8;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [ADDRW-1:0] init_cnt, init_cnt_nx;
  logic init_we, wr, rd, w_oob, r_oob, v1;
  logic [DATAW-1:0] mem [DEPTH];
  logic [DATAW-1:0] rword, d1;
  assign ready = state == RUN;
  assign w_oob = {1'b0, waddr} >= (ADDRW+1)'(DEPTH);
  assign r_oob = {1'b0, raddr} >= (ADDRW+1)'(DEPTH);
  assign wr = wen && ready && !w_oob;
  assign rd = ren && ready;
  always_ff @(posedge clk)
    if (!rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nx;
      init_cnt <= init_cnt_nx;
    end
  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    init_we     = 1'b0;
    if (state == INIT) begin
      if (ZERO_INIT != 0) begin
        init_we     = 1'b1;
        init_cnt_nx = init_cnt + 1'b1;
        state_nx    = init_cnt == ADDRW'(DEPTH - 1) ? RUN : INIT;
      end else begin
        state_nx = RUN;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst && init_we) mem[init_cnt] <= '0;
    else if (rst && wr)
      for (int i = 0; i < NB; i++)
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  // Out-of-range reads return zero; with forwarding, enabled write bytes override the stored word.
  always_comb begin
    rword = r_oob ? '0 : mem[raddr];
`ifdef MEM_BYPASS_EN
    for (int i = 0; i < NB; i++)
      if (wr && waddr == raddr && wbe[i]) rword[8*i +: 8] = wdata[8*i +: 8];
`endif
  end
  always_ff @(posedge clk)
    if (!rst) begin
      v1      <= 1'b0;
      d1      <= '0;
      oob_err <= 1'b0;
    end else begin
      v1 <= rd;
      if (rd) d1 <= rword;
      if ((rd && r_oob) || (wen && ready && w_oob)) oob_err <= 1'b1;
    end
  generate
    if (READ_LATENCY == 2) begin : g_rl2
      always_ff @(posedge clk)
        if (!rst) begin
          rvalid <= 1'b0;
          rdata  <= '0;
        end else begin
          rvalid <= v1;
          if (v1) rdata <= d1;
        end
    end else begin : g_rl1
      assign rvalid = v1;
      assign rdata  = d1;
    end
  endgenerate
endmodule

// File: tb/tb_memory_block_banked_rl.sv
// tb_memory_block_banked_rl: directed checks on a default instance (A) and a DEPTH=48, RL=2, no-sweep instance (B).
module tb_memory_block_banked_rl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic         rst_a = 1'b0, wen_a = 1'b0, ren_a = 1'b0;
  logic [5:0]   waddr_a = '0, raddr_a = '0;
  logic [127:0] wdata_a = '0;
  logic [15:0]  wbe_a = '0;
  logic         ready_a, rvalid_a, oob_a;
  logic [127:0] rdata_a;
  logic         rst_b = 1'b0, wen_b = 1'b0, ren_b = 1'b0;
  logic [5:0]   waddr_b = '0, raddr_b = '0;
  logic [31:0]  wdata_b = '0;
  logic [3:0]   wbe_b = '0;
  logic         ready_b, rvalid_b, oob_b;
  logic [31:0]  rdata_b;
  memory_block_banked_rl dut_a (
    .clk(clk), .rst(rst_a), .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a), .wbe(wbe_a),
    .ren(ren_a), .raddr(raddr_a), .ready(ready_a), .rvalid(rvalid_a), .rdata(rdata_a), .oob_err(oob_a)
  );
  memory_block_banked_rl #(.DATAW(32), .DEPTH(48), .READ_LATENCY(2), .ZERO_INIT(0)) dut_b (
    .clk(clk), .rst(rst_b), .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b), .wbe(wbe_b),
    .ren(ren_b), .raddr(raddr_b), .ready(ready_b), .rvalid(rvalid_b), .rdata(rdata_b), .oob_err(oob_b)
  );
  task automatic wr_a(input logic [5:0] a, input logic [127:0] d, input logic [15:0] be);
    wen_a = 1'b1; waddr_a = a; wdata_a = d; wbe_a = be;
    @(negedge clk);
    wen_a = 1'b0;
  endtask
  task automatic rd_a(input logic [5:0] a, output logic v, output logic [127:0] d);
    ren_a = 1'b1; raddr_a = a;
    @(negedge clk);
    ren_a = 1'b0; v = rvalid_a; d = rdata_a;
  endtask
  task automatic wr_b(input logic [5:0] a, input logic [31:0] d);
    wen_b = 1'b1; waddr_b = a; wdata_b = d; wbe_b = 4'hF;
    @(negedge clk);
    wen_b = 1'b0;
  endtask
  task automatic rd_b(input logic [5:0] a, output logic v_early, output logic v, output logic [31:0] d);
    ren_b = 1'b1; raddr_b = a;
    @(negedge clk);
    ren_b = 1'b0; v_early = rvalid_b;
    @(negedge clk);
    v = rvalid_b; d = rdata_b;
  endtask
  task automatic test_reset;
    int n;
    logic seen;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready_a, rvalid_a, oob_a} !== 3'b000 || rdata_a !== '0) begin
      errors++; $display("FAIL reset_a: ready/rvalid/oob=%b rdata=%h expected 000 and 0", {ready_a, rvalid_a, oob_a}, rdata_a);
    end
    checks++;
    if ({ready_b, rvalid_b, oob_b} !== 3'b000 || rdata_b !== '0) begin
      errors++; $display("FAIL reset_b: ready/rvalid/oob=%b rdata=%h expected 000 and 0", {ready_b, rvalid_b, oob_b}, rdata_b);
    end
    ren_a = 1'b1; raddr_a = 6'd1; rst_a = 1'b1;
    n = 0; seen = 1'b0;
    while (!ready_a && n < 100) begin
      @(negedge clk);
      n++;
      if (rvalid_a) seen = 1'b1;
    end
    ren_a = 1'b0;
    checks++;
    if (n !== 64) begin errors++; $display("FAIL sweep_len: ready after %0d cycles expected 64", n); end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL not_ready_read_a: rvalid seen=%b expected 0", seen); end
    ren_b = 1'b1; raddr_b = 6'd50; rst_b = 1'b1;
    @(negedge clk);
    ren_b = 1'b0;
    checks++;
    if (ready_b !== 1'b1) begin errors++; $display("FAIL no_sweep_ready: ready=%b expected 1", ready_b); end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rvalid_b) seen = 1'b1;
    end
    checks++;
    if ({seen, oob_b} !== 2'b00) begin errors++; $display("FAIL not_ready_read_b: rvalid_seen/oob=%b expected 00", {seen, oob_b}); end
  endtask
  task automatic test_zero_sweep;
    for (int i = 0; i < 64; i++) begin
      ren_a = 1'b1; raddr_a = 6'(i);
      @(negedge clk);
      checks++;
      if (rvalid_a !== 1'b1 || rdata_a !== '0) begin
        errors++; $display("FAIL zero_addr%0d: rvalid=%b rdata=%h expected 1 and 0", i, rvalid_a, rdata_a);
      end
    end
    ren_a = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_byte_enable;
    logic v;
    logic [127:0] d;
    localparam logic [127:0] EXP = 128'h0102030405060708090A0B0C0D0E0FFF;
    wr_a(6'd5, 128'h0102030405060708090A0B0C0D0E0F10, 16'hFFFF);
    wr_a(6'd5, {128{1'b1}}, 16'h0001);
    rd_a(6'd5, v, d);
    checks++;
    if (v !== 1'b1 || d !== EXP) begin errors++; $display("FAIL byte_en: rvalid=%b rdata=%h expected 1 %h", v, d, EXP); end
    @(negedge clk);
    checks++;
    if (rvalid_a !== 1'b0 || rdata_a !== EXP) begin
      errors++; $display("FAIL rdata_hold: rvalid=%b rdata=%h expected 0 %h", rvalid_a, rdata_a, EXP);
    end
    wr_a(6'd5, '0, 16'h0000);
    rd_a(6'd5, v, d);
    checks++;
    if (v !== 1'b1 || d !== EXP) begin errors++; $display("FAIL wbe_zero: rvalid=%b rdata=%h expected 1 %h", v, d, EXP); end
  endtask
  task automatic test_collision;
    logic v;
    logic [127:0] d, exp_full, exp_part;
`ifdef MEM_BYPASS_EN
    exp_full = {16{8'h55}};
    exp_part = {{8{8'h55}}, {8{8'h11}}};
`else
    exp_full = {16{8'hAA}};
    exp_part = {16{8'h55}};
`endif
    wr_a(6'd7, {16{8'hAA}}, 16'hFFFF);
    wen_a = 1'b1; waddr_a = 6'd7; wdata_a = {16{8'h55}}; wbe_a = 16'hFFFF;
    ren_a = 1'b1; raddr_a = 6'd7;
    @(negedge clk);
    wen_a = 1'b0; ren_a = 1'b0;
    checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== exp_full) begin
      errors++; $display("FAIL collide_full: rvalid=%b rdata=%h expected 1 %h", rvalid_a, rdata_a, exp_full);
    end
    wen_a = 1'b1; waddr_a = 6'd7; wdata_a = {16{8'h11}}; wbe_a = 16'h00FF;
    ren_a = 1'b1; raddr_a = 6'd7;
    @(negedge clk);
    wen_a = 1'b0; ren_a = 1'b0;
    checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== exp_part) begin
      errors++; $display("FAIL collide_part: rvalid=%b rdata=%h expected 1 %h", rvalid_a, rdata_a, exp_part);
    end
    wen_a = 1'b1; waddr_a = 6'd8; wdata_a = {16{8'h99}}; wbe_a = 16'hFFFF;
    ren_a = 1'b1; raddr_a = 6'd7;
    @(negedge clk);
    wen_a = 1'b0; ren_a = 1'b0;
    checks++;
    if (rdata_a !== {{8{8'h55}}, {8{8'h11}}}) begin
      errors++; $display("FAIL diff_addr: rdata=%h expected %h", rdata_a, {{8{8'h55}}, {8{8'h11}}});
    end
    rd_a(6'd8, v, d);
    checks++;
    if (v !== 1'b1 || d !== {16{8'h99}}) begin errors++; $display("FAIL diff_addr_wr: rvalid=%b rdata=%h expected 1 %h", v, d, {16{8'h99}}); end
  endtask
  task automatic test_back_to_back;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i + 1);
      wen_a = 1'b1; waddr_a = 6'(i); wdata_a = {16{b}}; wbe_a = 16'hFFFF;
      @(negedge clk);
    end
    wen_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i + 1);
      ren_a = 1'b1; raddr_a = 6'(i);
      @(negedge clk);
      checks++;
      if (rvalid_a !== 1'b1 || rdata_a !== {16{b}}) begin
        errors++; $display("FAIL b2b_%0d: rvalid=%b rdata=%h expected 1 %h", i, rvalid_a, rdata_a, {16{b}});
      end
    end
    ren_a = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid_a !== 1'b0) begin errors++; $display("FAIL b2b_end: rvalid=%b expected 0", rvalid_a); end
  endtask
  task automatic test_reset_mid;
    int n;
    logic seen, v;
    logic [127:0] d;
    ren_a = 1'b1; raddr_a = 6'd3; rst_a = 1'b0;
    @(negedge clk);
    ren_a = 1'b0; rst_a = 1'b1;
    checks++;
    if ({ready_a, rvalid_a} !== 2'b00 || rdata_a !== '0) begin
      errors++; $display("FAIL drop_inflight_a: ready/rvalid=%b rdata=%h expected 00 and 0", {ready_a, rvalid_a}, rdata_a);
    end
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rvalid_a || ready_a) seen = 1'b1;
    end
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    n = 0;
    while (!ready_a && n < 100) begin
      @(negedge clk);
      n++;
      if (rvalid_a) seen = 1'b1;
    end
    checks++;
    if (n !== 64) begin errors++; $display("FAIL resweep_len: ready after %0d cycles expected 64", n); end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL resweep_quiet: rvalid/ready seen=%b expected 0", seen); end
    rd_a(6'd3, v, d);
    checks++;
    if (v !== 1'b1 || d !== '0) begin errors++; $display("FAIL resweep_zero: rvalid=%b rdata=%h expected 1 and 0", v, d); end
  endtask
  task automatic test_oob;
    logic ve, v;
    logic [31:0] d;
    wr_b(6'd2, 32'hCAFEBABE);
    wr_b(6'd47, 32'h00C0FFEE);
    rd_b(6'd2, ve, v, d);
    checks++;
    if ({ve, v} !== 2'b01 || d !== 32'hCAFEBABE) begin
      errors++; $display("FAIL rl2_timing: rvalid T+1/T+2=%b rdata=%h expected 01 cafebabe", {ve, v}, d);
    end
    @(negedge clk);
    checks++;
    if (rvalid_b !== 1'b0 || rdata_b !== 32'hCAFEBABE) begin
      errors++; $display("FAIL rl2_hold: rvalid=%b rdata=%h expected 0 cafebabe", rvalid_b, rdata_b);
    end
    rd_b(6'd47, ve, v, d);
    checks++;
    if ({ve, v, oob_b} !== 3'b010 || d !== 32'h00C0FFEE) begin
      errors++; $display("FAIL last_addr: rvalid/oob=%b rdata=%h expected 010 00c0ffee", {ve, v, oob_b}, d);
    end
    wr_b(6'd50, 32'h12345678);
    checks++;
    if (oob_b !== 1'b1) begin errors++; $display("FAIL oob_write: oob_err=%b expected 1", oob_b); end
    rd_b(6'd50, ve, v, d);
    checks++;
    if ({ve, v} !== 2'b01 || d !== 32'h0) begin errors++; $display("FAIL oob_read: rvalid=%b rdata=%h expected 01 0", {ve, v}, d); end
    rd_b(6'd2, ve, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'hCAFEBABE || oob_b !== 1'b1) begin
      errors++; $display("FAIL oob_alias: rvalid=%b rdata=%h oob=%b expected 1 cafebabe 1", v, d, oob_b);
    end
  endtask
  task automatic test_reset_b;
    logic ve, v;
    logic [31:0] d;
    ren_b = 1'b1; raddr_b = 6'd2;
    @(negedge clk);
    ren_b = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    checks++;
    if ({ready_b, rvalid_b, oob_b} !== 3'b000 || rdata_b !== '0) begin
      errors++; $display("FAIL drop_inflight_b: ready/rvalid/oob=%b rdata=%h expected 000 0", {ready_b, rvalid_b, oob_b}, rdata_b);
    end
    @(negedge clk);
    checks++;
    if ({ready_b, rvalid_b} !== 2'b10) begin errors++; $display("FAIL drop_stage2_b: ready/rvalid=%b expected 10", {ready_b, rvalid_b}); end
    rd_b(6'd2, ve, v, d);
    checks++;
    if (v !== 1'b1 || d !== 32'hCAFEBABE) begin errors++; $display("FAIL mem_persist: rvalid=%b rdata=%h expected 1 cafebabe", v, d); end
    rd_b(6'd48, ve, v, d);
    checks++;
    if ({v, oob_b} !== 2'b11 || d !== 32'h0) begin
      errors++; $display("FAIL oob_read_only: rvalid/oob=%b rdata=%h expected 11 0", {v, oob_b}, d);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    test_reset;
    test_zero_sweep;
    test_byte_enable;
    test_collision;
    test_back_to_back;
    test_reset_mid;
    test_oob;
    test_reset_b;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
